cnn_window_fetch: RTL and testbench

CNN_WINDOW_FETCH -- requirements
Module: cnn_window_fetch

---
 rtl/cnn_pkg.sv | 16 +
 rtl/cnn_win_ram.sv | 23 ++
 rtl/cnn_window_fetch.sv | 181 ++++++++++++++++++
 tb/tb_cnn_window_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN window fetch block.
package cnn_pkg;

    // Read-side FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } rd_state_e;

    // Address width for an n-entry memory (never narrower than 1 bit)
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_win_ram.sv
// Frame store: simple dual-port RAM, synchronous write, registered read.
module cnn_win_ram #(
    parameter int DEPTH = 784,
    parameter int AW    = 10,
    parameter int DW    = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port and 1-cycle-latency read port; contents are never reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/cnn_window_fetch.sv
// Unpacks received bytes into a frame store and streams KxK windows
// (stride 1, raster order) to a downstream core as soon as each window's
// bottom-right pixel has been written.
module cnn_window_fetch
    import cnn_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3,
    parameter int PIX_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       byte_in,
    input  logic             byte_vld,
    output logic             byte_rdy,
    input  logic             frm_clr,
    input  logic             core_bsy,
    output logic [PIX_W-1:0] pix_out,
    output logic             pix_vld,
    output logic             win_first,
    output logic             win_last,
    output logic             frm_done,
    output logic             ovf
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int NWIN = (IMG_W - K + 1) * (IMG_H - K + 1);
    localparam int PPB  = 8 / PIX_W;
    localparam int AW   = addr_w(NPIX);
    // Pointer width must hold br_ptr after the final advance (up to NPIX-1+K)
    localparam int PW   = addr_w(NPIX + K);
    localparam int UW   = addr_w(PPB + 1);
    localparam int KW   = addr_w(K);
    localparam int CW   = addr_w(IMG_W - K + 1);

    localparam logic [PW-1:0] NPIX_P   = PW'(NPIX);
    localparam logic [PW-1:0] BR0      = PW'((K - 1) * IMG_W + K - 1);
    localparam logic [PW-1:0] NWIN_P   = PW'(NWIN);
    localparam logic [PW-1:0] NWIN_M1  = PW'(NWIN - 1);
    localparam logic [PW-1:0] ROW_JMP  = PW'(K);
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W - K + 1);
    localparam logic [KW-1:0] KMAX     = KW'(K - 1);
    localparam logic [CW-1:0] CMAX     = CW'(IMG_W - K);

    logic [7:0]       sh;
    logic [UW-1:0]    ucnt;
    logic [PW-1:0]    wr_ptr;
    logic             we;
    logic [PW-1:0]    br_ptr;
    logic [PW-1:0]    win_cnt;
    logic [CW-1:0]    col;
    logic [KW-1:0]    kr, kc;
    logic [AW-1:0]    rd_ptr;
    logic [PIX_W-1:0] rdata;
    rd_state_e        state;
    logic             acc, start, wlast;

    assign byte_rdy = (ucnt == '0);
    assign acc      = byte_vld & byte_rdy;
    assign we       = (ucnt != '0) && (wr_ptr != NPIX_P);
    assign start    = (state == ST_IDLE) && !core_bsy && (br_ptr < wr_ptr) && (win_cnt != NWIN_P);
    assign wlast    = (state == ST_FETCH) && (kr == KMAX) && (kc == KMAX);

    // Byte acceptance, LSB-first unpack, write pointer and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh     <= '0;
            ucnt   <= '0;
            wr_ptr <= '0;
            ovf    <= 1'b0;
        end else if (frm_clr) begin
            sh     <= '0;
            ucnt   <= '0;
            wr_ptr <= '0;
            ovf    <= 1'b0;
        end else if (acc) begin
            if (wr_ptr == NPIX_P) begin
                ovf <= 1'b1;
            end else begin
                sh   <= byte_in;
                ucnt <= UW'(PPB);
            end
        end else if (ucnt != '0) begin
            sh   <= sh >> PIX_W;
            ucnt <= ucnt - 1'b1;
            if (we) wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Window sequencer: waits for the bottom-right pixel, then walks KxK addresses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            br_ptr  <= BR0;
            win_cnt <= '0;
            col     <= '0;
            kr      <= '0;
            kc      <= '0;
            rd_ptr  <= '0;
        end else if (frm_clr) begin
            state   <= ST_IDLE;
            br_ptr  <= BR0;
            win_cnt <= '0;
            col     <= '0;
            kr      <= '0;
            kc      <= '0;
            rd_ptr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_FETCH;
                        rd_ptr <= AW'(br_ptr - BR0);
                        kr     <= '0;
                        kc     <= '0;
                    end
                end
                ST_FETCH: begin
                    if (kc == KMAX) begin
                        kc     <= '0;
                        kr     <= kr + 1'b1;
                        rd_ptr <= rd_ptr + ROW_STEP;
                    end else begin
                        kc     <= kc + 1'b1;
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    if (wlast) begin
                        win_cnt <= win_cnt + 1'b1;
                        if (col == CMAX) begin
                            col    <= '0;
                            br_ptr <= br_ptr + ROW_JMP;
                        end else begin
                            col    <= col + 1'b1;
                            br_ptr <= br_ptr + 1'b1;
                        end
                        state <= (win_cnt == NWIN_M1) ? ST_DONE : ST_IDLE;
                    end
                end
                default: state <= ST_DONE;
            endcase
        end
    end

    // Output flags trail the address by one cycle to line up with RAM data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_vld   <= 1'b0;
            win_first <= 1'b0;
            win_last  <= 1'b0;
            frm_done  <= 1'b0;
        end else if (frm_clr) begin
            pix_vld   <= 1'b0;
            win_first <= 1'b0;
            win_last  <= 1'b0;
            frm_done  <= 1'b0;
        end else begin
            pix_vld   <= (state == ST_FETCH);
            win_first <= (state == ST_FETCH) && (kr == '0) && (kc == '0);
            win_last  <= wlast;
            frm_done  <= win_last && (state == ST_DONE);
        end
    end

    // RAM output is unreset, so hold pix_out at 0 whenever it is not valid
    assign pix_out = pix_vld ? rdata : '0;

    cnn_win_ram #(
        .DEPTH (NPIX),
        .AW    (AW),
        .DW    (PIX_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (sh[PIX_W-1:0]),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_cnn_window_fetch.sv
// Bench for cnn_window_fetch: default 28x28/K=3/1-bit instance plus a
// 4x4/K=2/8-bit instance, random image data against a window-level model.
module tb_cnn_window_fetch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // default instance
    logic [7:0] bin0;
    logic       bvld0, brdy0, clr0, bsy0;
    logic [0:0] pix0;
    logic       pv0, wf0, wl0, fd0, ovf0;

    // small 8-bit instance
    logic [7:0] bin1;
    logic       bvld1, brdy1, clr1, bsy1;
    logic [7:0] pix1;
    logic       pv1, wf1, wl1, fd1, ovf1;

    cnn_window_fetch u0 (
        .clk(clk), .rst_n(rst_n), .byte_in(bin0), .byte_vld(bvld0), .byte_rdy(brdy0),
        .frm_clr(clr0), .core_bsy(bsy0), .pix_out(pix0), .pix_vld(pv0),
        .win_first(wf0), .win_last(wl0), .frm_done(fd0), .ovf(ovf0)
    );

    cnn_window_fetch #(.IMG_W(4), .IMG_H(4), .K(2), .PIX_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .byte_in(bin1), .byte_vld(bvld1), .byte_rdy(brdy1),
        .frm_clr(clr1), .core_bsy(bsy1), .pix_out(pix1), .pix_vld(pv1),
        .win_first(wf1), .win_last(wl1), .frm_done(fd1), .ovf(ovf1)
    );

    // captured output streams
    logic [7:0] q0[$];
    logic       f0[$], l0[$];
    int         done0 = 0, dbad0 = 0, run0 = 0, runbad0 = 0;
    logic       lprev0 = 1'b0;
    logic [7:0] q1[$];
    logic       f1[$], l1[$];
    int         done1 = 0;

    always @(negedge clk) begin
        if (pv0) begin
            q0.push_back({7'd0, pix0});
            f0.push_back(wf0);
            l0.push_back(wl0);
            run0 = run0 + 1;
        end else begin
            if (run0 != 0 && run0 != 9) runbad0 = runbad0 + 1;
            run0 = 0;
        end
        if (fd0) begin
            done0 = done0 + 1;
            if (!lprev0) dbad0 = dbad0 + 1;
        end
        lprev0 = wl0;
        if (pv1) begin
            q1.push_back(pix1);
            f1.push_back(wf1);
            l1.push_back(wl1);
        end
        if (fd1) done1 = done1 + 1;
    end

    // reference images
    logic [7:0] img0 [784];
    int         wp0 = 0;
    logic [7:0] img1 [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // windows whose bottom-right pixel has been written so far
    function automatic int nwin_avail0();
        int n = 0;
        for (int oy = 0; oy < 26; oy++)
            for (int ox = 0; ox < 26; ox++)
                if ((oy + 2) * 28 + ox + 2 < wp0) n++;
        return n;
    endfunction

    function automatic logic [7:0] exp0(input int w, input int i);
        int ox = w % 26;
        int oy = w / 26;
        return img0[(oy + i / 3) * 28 + ox + i % 3];
    endfunction

    function automatic logic [7:0] exp1(input int w, input int i);
        int ox = w % 3;
        int oy = w / 3;
        return img1[(oy + i / 2) * 4 + ox + i % 2];
    endfunction

    task automatic send0(input logic [7:0] b);
        int n = 0;
        while (brdy0 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n == 200) chk("send0_rdy", {31'd0, brdy0}, 1);
        bin0  = b;
        bvld0 = 1'b1;
        @(negedge clk);
        bvld0 = 1'b0;
        for (int k = 0; k < 8; k++)
            if (wp0 < 784) begin img0[wp0] = {7'd0, b[k]}; wp0++; end
    endtask

    task automatic send1(input logic [7:0] b);
        int n = 0;
        while (brdy1 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n == 200) chk("send1_rdy", {31'd0, brdy1}, 1);
        bin1  = b;
        bvld1 = 1'b1;
        @(negedge clk);
        bvld1 = 1'b0;
    endtask

    task automatic wait_q0(input int n, input int lim, input string tag);
        int c = 0;
        while (q0.size() < n && c < lim) begin @(negedge clk); c++; end
        chk(tag, (q0.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic chk_stream0(input string tag);
        int nw = nwin_avail0();
        chk($sformatf("%s_npix", tag), q0.size(), nw * 9);
        for (int i = 0; i < q0.size() && i < nw * 9; i++) begin
            chk($sformatf("%s_px%0d", tag, i), q0[i], exp0(i / 9, i % 9));
            chk($sformatf("%s_first%0d", tag, i), f0[i], (i % 9) == 0);
            chk($sformatf("%s_last%0d", tag, i), l0[i], (i % 9) == 8);
        end
    endtask

    task automatic clear_mon0();
        q0.delete(); f0.delete(); l0.delete();
    endtask

    initial begin
        int n;
        int c;
        bin0 = '0; bvld0 = 0; clr0 = 0; bsy0 = 0;
        bin1 = '0; bvld1 = 0; clr1 = 0; bsy1 = 0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_rdy", brdy0, 1);
        chk("rst_pix", pix0, 0);
        chk("rst_flags", {pv0, wf0, wl0, fd0, ovf0}, 0);
        chk("rst_rdy1", brdy1, 1);
        chk("rst_pix1", pix1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 7 bytes: no window yet; 8th byte releases window 0 (and its row-mates)
        wp0 = 0;
        for (int b = 0; b < 7; b++) send0(8'($urandom));
        repeat (40) @(negedge clk);
        chk("no_win_7B", q0.size(), 0);
        send0(8'($urandom));
        wait_q0(9, 300, "w0_reach");
        repeat (100) @(negedge clk);
        chk_stream0("w0");

        // stream more, stall with core_bsy, then finish the frame
        for (int b = 8; b < 40; b++) send0(8'($urandom));
        bsy0 = 1'b1;
        repeat (15) @(negedge clk);
        n = q0.size();
        for (int b = 40; b < 60; b++) send0(8'($urandom));
        repeat (10) @(negedge clk);
        chk("bsy_hold", q0.size(), n);
        bsy0 = 1'b0;
        for (int b = 60; b < 98; b++) send0(8'($urandom));
        c = 0;
        while (done0 == 0 && c < 20000) begin @(negedge clk); c++; end
        repeat (20) @(negedge clk);
        chk("frm_done_cnt", done0, 1);
        chk("frm_done_after_last", dbad0, 0);
        chk("run_len9", runbad0, 0);
        chk_stream0("frm");
        chk("nwin_total", q0.size(), 676 * 9);
        if (q0.size() > 26 * 9) chk("win26_px0", q0[26 * 9], img0[28]);

        // overflow byte, then frm_clr
        n = q0.size();
        chk("ovf_pre", ovf0, 0);
        send0(8'($urandom));
        repeat (3) @(negedge clk);
        chk("ovf_set", ovf0, 1);
        chk("ovf_no_pix", q0.size(), n);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        chk("clr_ovf", ovf0, 0);
        chk("clr_rdy", brdy0, 1);

        // frm_clr mid-window
        clear_mon0();
        wp0 = 0;
        for (int b = 0; b < 8; b++) send0(8'($urandom));
        wait_q0(3, 300, "clrmid_reach");
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        chk("clrmid_pv", pv0, 0);
        repeat (2) @(negedge clk);
        clear_mon0();
        runbad0 = 0;
        wp0 = 0;
        for (int b = 0; b < 8; b++) send0(8'($urandom));
        wait_q0(9, 300, "clr_new_reach");
        repeat (100) @(negedge clk);
        chk_stream0("clr_new");

        // rst_n mid-window
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        repeat (2) @(negedge clk);
        clear_mon0();
        wp0 = 0;
        for (int b = 0; b < 8; b++) send0(8'($urandom));
        wait_q0(3, 300, "rstmid_reach");
        rst_n = 1'b0;
        #1;
        chk("rstmid_pv_async", pv0, 0);
        chk("rstmid_rdy", brdy0, 1);
        chk("rstmid_pix", pix0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_pv_after", pv0, 0);
        repeat (2) @(negedge clk);
        clear_mon0();
        runbad0 = 0;
        wp0 = 0;
        for (int b = 0; b < 8; b++) send0(8'($urandom));
        wait_q0(9, 300, "rst_new_reach");
        repeat (100) @(negedge clk);
        chk_stream0("rst_new");
        chk("rst_new_runs", runbad0, 0);

        // 8-bit pixels, 4x4 image, K=2
        for (int p = 0; p < 16; p++) begin
            img1[p] = (p == 5) ? 8'hA5 : 8'($urandom);
            send1(img1[p]);
        end
        c = 0;
        while (done1 == 0 && c < 500) begin @(negedge clk); c++; end
        repeat (10) @(negedge clk);
        chk("p8_npix", q1.size(), 36);
        chk("p8_done", done1, 1);
        for (int i = 0; i < q1.size() && i < 36; i++) begin
            chk($sformatf("p8_px%0d", i), q1[i], exp1(i / 4, i % 4));
            chk($sformatf("p8_first%0d", i), f1[i], (i % 4) == 0);
            chk($sformatf("p8_last%0d", i), l1[i], (i % 4) == 3);
        end
        if (q1.size() > 16) chk("p8_a5", q1[16], 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
